psum_accumulator: RTL and testbench

Downstream stage of the weight-stationary PE column. It consumes the column's bottom partial sum (`sum_o`, signed `T_D_SIZE`) one output column at a time and accumulates it across `F_WIDTH` filter-row passes in a line buffer. On the final pass it adds bias, applies an activation/clamp, shifts and saturates, then emits one output pixel over a valid/ready handshake.

---
 rtl/psum_acc_pkg.sv | 31 +++
 rtl/psum_line_buffer.sv | 28 ++
 rtl/psum_accumulator.sv | 136 +++++++++++++
 tb/tb_psum_accumulator.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/psum_acc_pkg.sv
// Shared types and helpers for the partial-sum accumulator: FSM states,
// accumulator width rule and signed saturation.
package psum_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2
  } state_t;

  function automatic int acc_width(input int t_d_size, input int f_width);
    return t_d_size + $clog2(f_width);
  endfunction

  // Operates on a 64-bit sign-extended value so one helper serves any ACC_W <= 64.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v,
                                                input int o_width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (o_width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (v > max_v) begin
      return max_v;
    end
    if (v < min_v) begin
      return min_v;
    end
    return v;
  endfunction

endpackage

// File: rtl/psum_line_buffer.sv
// Line buffer for running column sums: one synchronous write port and one
// asynchronous read port, contents are never reset.
module psum_line_buffer
  import psum_acc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 40,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates PE-column partial sums over F_WIDTH passes, then bias/activation/
// shift/saturate on the final pass. Define PSUM_ACC_RELU_EN to enable ReLU.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int T_D_SIZE = 37,
  parameter int O_D_SIZE = 16,
  parameter int F_WIDTH  = 5,
  parameter int LINE_LEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_en,
  input  logic [T_D_SIZE-1:0]        psum_i,
  input  logic                       psum_valid_i,
  output logic                       psum_ready_o,
  input  logic [T_D_SIZE-1:0]        bias_i,
  input  logic [4:0]                 shift_i,
  output logic [O_D_SIZE-1:0]        out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [$clog2(F_WIDTH)-1:0] pass_o,
  output logic                       row_done_o
);

  localparam int ACC_W = acc_width(T_D_SIZE, F_WIDTH);
  localparam int EXT_W = ACC_W - T_D_SIZE;
  localparam int PW    = $clog2(F_WIDTH);
  localparam int CW    = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam logic [CW-1:0] COL_LAST       = CW'(LINE_LEN - 1);
  localparam logic [PW-1:0] PASS_PRE_FINAL = PW'(F_WIDTH - 2);

  if (F_WIDTH < 2 || ACC_W > 64) begin : g_param_check
    $error("psum_accumulator: F_WIDTH must be >= 2 and ACC_W <= 64");
  end

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [PW-1:0]         r_pass;
  logic [O_D_SIZE-1:0]   r_out_data;
  logic                  r_out_valid;
  logic                  r_row_done;

  logic                  w_accept;
  logic                  w_col_wrap;
  logic                  w_buf_we;
  logic [ACC_W-1:0]      w_buf_rd;
  logic [ACC_W-1:0]      w_buf_wr;
  logic signed [ACC_W-1:0] w_psum_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum_v;
  logic signed [ACC_W-1:0] w_act_v;
  logic signed [63:0]    w_act_64;
  logic signed [63:0]    w_shifted;
  logic signed [63:0]    w_sat;

  assign psum_ready_o = clk_en & ~((r_state == FINAL) & r_out_valid & ~out_ready_i);
  assign w_accept     = psum_valid_i & psum_ready_o;
  assign w_col_wrap   = (r_col == COL_LAST);

  assign w_psum_ext = {{EXT_W{psum_i[T_D_SIZE-1]}}, psum_i};
  assign w_bias_ext = {{EXT_W{bias_i[T_D_SIZE-1]}}, bias_i};

  // Pass 0 overwrites stale contents, so the buffer itself needs no reset.
  assign w_buf_wr = (r_pass == '0) ? w_psum_ext : (w_buf_rd + w_psum_ext);
  assign w_buf_we = w_accept & (r_state != FINAL);

  assign w_sum_v = w_buf_rd + w_psum_ext + w_bias_ext;
`ifdef PSUM_ACC_RELU_EN
  assign w_act_v = w_sum_v[ACC_W-1] ? '0 : w_sum_v;
`else
  assign w_act_v = w_sum_v;
`endif
  assign w_act_64  = 64'(w_act_v);
  assign w_shifted = w_act_64 >>> shift_i;
  assign w_sat     = sat_to(w_shifted, O_D_SIZE);

  psum_line_buffer #(
    .DEPTH (LINE_LEN),
    .WIDTH (ACC_W),
    .AW    (CW)
  ) u_line_buffer (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_col),
    .i_wdata (w_buf_wr),
    .i_raddr (r_col),
    .o_rdata (w_buf_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_col       <= '0;
      r_pass      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_row_done  <= 1'b0;
    end else if (clk_en) begin
      r_row_done <= 1'b0;
      if (r_out_valid && out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_col <= w_col_wrap ? '0 : r_col + 1'b1;
        case (r_state)
          IDLE, ACCUM: begin
            if (w_col_wrap) begin
              r_pass  <= r_pass + 1'b1;
              r_state <= (r_pass == PASS_PRE_FINAL) ? FINAL : ACCUM;
            end else begin
              r_state <= ACCUM;
            end
          end
          FINAL: begin
            // A final beat is only accepted when the output slot is free or draining.
            r_out_data  <= w_sat[O_D_SIZE-1:0];
            r_out_valid <= 1'b1;
            if (w_col_wrap) begin
              r_pass     <= '0;
              r_state    <= IDLE;
              r_row_done <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign pass_o      = r_pass;
  assign row_done_o  = r_row_done;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against a per-row arithmetic model
// (sum of passes + bias, optional ReLU, shift, clamp).
module tb_psum_accumulator;

  localparam int T_D   = 37;
  localparam int O_D   = 16;
  localparam int FW    = 5;
  localparam int LL    = 4;
  localparam int BEATS = FW * LL;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   clk_en = 1'b0;
  logic [T_D-1:0]         psum_i = '0;
  logic                   psum_valid_i = 1'b0;
  logic                   psum_ready_o;
  logic [T_D-1:0]         bias_i = '0;
  logic [4:0]             shift_i = '0;
  logic [O_D-1:0]         out_data_o;
  logic                   out_valid_o;
  logic                   out_ready_i = 1'b1;
  logic [$clog2(FW)-1:0]  pass_o;
  logic                   row_done_o;

  int     n_checks = 0;
  int     n_pass   = 0;

  longint m_acc [LL];
  int     m_beats = 0;
  bit     m_out_valid = 1'b0;
  longint m_out_data = 0;
  bit     m_row_done = 1'b0;
  longint cur_bias = 0;
  int     cur_shift = 0;

  psum_accumulator #(
    .T_D_SIZE (T_D),
    .O_D_SIZE (O_D),
    .F_WIDTH  (FW),
    .LINE_LEN (LL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .psum_i       (psum_i),
    .psum_valid_i (psum_valid_i),
    .psum_ready_o (psum_ready_o),
    .bias_i       (bias_i),
    .shift_i      (shift_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .pass_o       (pass_o),
    .row_done_o   (row_done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_pixel(input longint total, input longint bias, input int sh);
    longint v;
    v = total + bias;
`ifdef PSUM_ACC_RELU_EN
    if (v < 0) v = 0;
`endif
    v = v >>> sh;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  function automatic longint rand_val();
    longint r;
    r = longint'($signed($urandom));
    return r >>> $urandom_range(0, 24);
  endfunction

  // One clock: check outputs at negedge, advance the model, cross the posedge.
  task automatic cycle(output bit accepted);
    bit exp_ready;
    bit fire;
    int p;
    int c;
    @(negedge clk);
    exp_ready = clk_en && !((m_beats >= (FW - 1) * LL) && m_out_valid && !out_ready_i);
    chk("psum_ready", longint'(psum_ready_o), longint'(exp_ready));
    chk("pass_o", longint'(pass_o), longint'(m_beats / LL));
    chk("out_valid", longint'(out_valid_o), longint'(m_out_valid));
    if (m_out_valid) chk("out_data", longint'($signed(out_data_o)), m_out_data);
    chk("row_done", longint'(row_done_o), longint'(m_row_done));
    accepted = psum_valid_i && exp_ready;
    fire = m_out_valid && out_ready_i;
    if (clk_en) begin
      m_row_done = 1'b0;
      if (fire) $display("pixel out: %0d", m_out_data);
      if (accepted) begin
        p = m_beats / LL;
        c = m_beats % LL;
        if (p == 0) m_acc[c] = longint'($signed(psum_i));
        else m_acc[c] = m_acc[c] + longint'($signed(psum_i));
        if (p == FW - 1) begin
          m_out_data  = ref_pixel(m_acc[c], cur_bias, cur_shift);
          m_out_valid = 1'b1;
        end else if (fire) begin
          m_out_valid = 1'b0;
        end
        m_beats++;
        if (m_beats == BEATS) begin
          m_beats    = 0;
          m_row_done = 1'b1;
        end
      end else if (fire) begin
        m_out_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ctrl: 0 plain, 1 random handshakes, 2 output stall in final pass, 3 clk_en stall
  task automatic run_row(input int n, input bit rnd_val, input longint fixed,
                         input longint bias, input int sh, input int ctrl);
    int     got = 0;
    int     budget = 0;
    int     stall = 0;
    bit     a;
    longint v;
    cur_bias  = bias;
    cur_shift = sh;
    bias_i    = bias[T_D-1:0];
    shift_i   = sh[4:0];
    v = rnd_val ? rand_val() : fixed;
    while (got < n && budget < 500) begin
      psum_i       = v[T_D-1:0];
      psum_valid_i = 1'b1;
      out_ready_i  = 1'b1;
      clk_en       = 1'b1;
      if (ctrl == 1) begin
        psum_valid_i = ($urandom_range(0, 3) != 0);
        out_ready_i  = ($urandom_range(0, 2) != 0);
        clk_en       = ($urandom_range(0, 7) != 0);
      end else if (ctrl == 2 && got == (FW - 1) * LL + 1 && stall < 4) begin
        out_ready_i = 1'b0;
        stall++;
      end else if (ctrl == 3 && got == 6 && stall < 3) begin
        clk_en = 1'b0;
        stall++;
      end
      cycle(a);
      budget++;
      if (a) begin
        got++;
        v = rnd_val ? rand_val() : fixed;
      end
    end
    if (got < n) chk("row_timeout", longint'(got), longint'(n));
  endtask

  task automatic drain();
    bit a;
    psum_valid_i = 1'b0;
    out_ready_i  = 1'b1;
    clk_en       = 1'b1;
    repeat (3) cycle(a);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    psum_valid_i = 1'b0;
    #1;
    chk("rst_pass", longint'(pass_o), 0);
    chk("rst_valid", longint'(out_valid_o), 0);
    chk("rst_row_done", longint'(row_done_o), 0);
    chk("rst_data", longint'(out_data_o), 0);
    m_beats     = 0;
    m_out_valid = 1'b0;
    m_out_data  = 0;
    m_row_done  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    apply_reset();
    clk_en = 1'b1;

    run_row(BEATS, 1'b0, 1, 0, 0, 0);              drain();
    run_row(BEATS, 1'b0, 1000, -8, 2, 0);          drain();
    run_row(BEATS, 1'b0, 64'sd1 <<< 20, 0, 0, 0);  drain();
    run_row(BEATS, 1'b0, -(64'sd1 <<< 20), 0, 0, 0); drain();
    run_row(BEATS, 1'b0, 7, 3, 0, 2);              drain();
    run_row(BEATS, 1'b0, 11, -5, 1, 3);            drain();

    // Abort at pass 2, column 1, then a clean row of 3s.
    run_row(2 * LL + 1, 1'b0, 3, 0, 0, 0);
    apply_reset();
    run_row(BEATS, 1'b0, 3, 0, 0, 0);              drain();

    for (int r = 0; r < 12; r++) begin
      run_row(BEATS, 1'b1, 0, rand_val(), int'($urandom_range(0, 20)), 1);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
